// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared types and constants for the PS/2 keyboard receiver.
//   ps2_state_e  : receiver frame FSM states
//   PS2_EXT/BRK  : scan-code prefix bytes (extended key / key release)
//   ps2_evt_t    : packed key event {ext, brk, code[7:0]} stored in the FIFO
//   odd_parity_ok: PS/2 frames carry odd parity over data + parity bit
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int unsigned PS2_EVT_W = 10;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  // True when the nine received bits hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo -- first-word fall-through event FIFO with sticky overflow.
//   clk, rst      : clock, async active-high reset
//   push/push_data: write request and payload (dropped when full w/o pop)
//   pop           : remove head entry; ignored while empty
//   clr_ovf       : clear sticky overflow (a coincident drop wins)
//   head          : registered head entry; holds last head when empty
//   valid, level  : non-empty flag and entry count
//   overflow      : sticky drop indicator
module ps2_evt_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     clr_ovf,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_n;
  logic [AW-1:0]    rd_ptr_n;
  logic [LW-1:0]    level_n;
  logic [WIDTH-1:0] head_n;
  logic             overflow_n;
  logic             do_push_s;
  logic             do_pop_s;

  // Next-state computation for pointers, level, head and overflow.
  always_comb begin
    do_pop_s  = pop && (level != LW'(0));
    // When full, a same-cycle pop frees the slot the push needs.
    do_push_s = push && ((level != LW'(DEPTH)) || do_pop_s);

    case ({do_push_s, do_pop_s})
      2'b10:   level_n = level + LW'(1);
      2'b01:   level_n = level - LW'(1);
      default: level_n = level;
    endcase

    if (do_push_s) begin
      wr_ptr_n = wr_ptr_r + AW'(1);
    end else begin
      wr_ptr_n = wr_ptr_r;
    end

    if (do_pop_s) begin
      rd_ptr_n = rd_ptr_r + AW'(1);
    end else begin
      rd_ptr_n = rd_ptr_r;
    end

    // Head is registered; the entry being written this edge may become head.
    if (level_n == LW'(0)) begin
      head_n = head;
    end else if (do_push_s && (wr_ptr_r == rd_ptr_n)) begin
      head_n = push_data;
    end else begin
      head_n = mem_r[rd_ptr_n];
    end

    if (push && !do_push_s) begin
      overflow_n = 1'b1;
    end else if (clr_ovf) begin
      overflow_n = 1'b0;
    end else begin
      overflow_n = overflow;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer, level, head and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      level    <= LW'(0);
      valid    <= 1'b0;
      head     <= WIDTH'(0);
      overflow <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_n;
      rd_ptr_r <= rd_ptr_n;
      level    <= level_n;
      valid    <= (level_n != LW'(0));
      head     <= head_n;
      overflow <= overflow_n;
    end
  end

endmodule

// File: rtl/ps2_key_rx.sv
// ps2_key_rx -- PS/2 keyboard receiver producing {ext, brk, code} key events.
//   clk, rst          : sole clock, async active-high reset
//   ps2_clk, ps2_data : raw PS/2 bus lines (asynchronous)
//   rd_en             : pop head event (ignored while valid is low)
//   clr_ovf           : clear sticky overflow
//   code, ext, brk    : head event (first-word fall-through)
//   valid, level      : FIFO non-empty, entries held
//   overflow          : sticky, an event was dropped
//   parity_err        : one-cycle pulse, bad parity with good stop bit
//   frame_err         : one-cycle pulse, bad start/stop bit or timeout
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ps2_clk,
  input  logic                         ps2_data,
  input  logic                         rd_en,
  input  logic                         clr_ovf,
  output logic [7:0]                   code,
  output logic                         ext,
  output logic                         brk,
  output logic                         valid,
  output logic [$clog2(FIFO_DEPTH):0]  level,
  output logic                         overflow,
  output logic                         parity_err,
  output logic                         frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  // Fires one cycle early so the registered frame_err lands exactly
  // TIMEOUT_CYCLES after the last strobe.
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 2);

  // Input conditioning
  logic          clk_meta_r;
  logic          clk_sync_r;
  logic          data_meta_r;
  logic          data_sync_r;
  logic          filt_clk_r;
  logic [FW-1:0] filt_cnt_r;
  logic          fall_s;
  logic          strobe_r;
  logic          sample_r;

  // Frame FSM
  ps2_state_e    state_r;
  ps2_state_e    state_n;
  logic [2:0]    bit_idx_r;
  logic [2:0]    bit_idx_n;
  logic [7:0]    shift_r;
  logic [7:0]    shift_n;
  logic          par_r;
  logic          par_n;
  logic [TW-1:0] timer_r;
  logic [TW-1:0] timer_n;
  logic          accept_s;
  logic          perr_s;
  logic          ferr_s;

  // Event assembly
  logic          ext_pend_r;
  logic          brk_pend_r;
  logic          push_r;
  ps2_evt_t      push_evt_r;
  logic [PS2_EVT_W-1:0] head_s;
  ps2_evt_t      head_evt_s;

  // Filtered clock is about to drop: low has been stable FILTER_LEN samples.
  assign fall_s = filt_clk_r && !clk_sync_r && (filt_cnt_r == FILT_LAST);

  // Synchronisers, glitch filter and falling-edge sample strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
      filt_clk_r  <= 1'b1;
      filt_cnt_r  <= FW'(0);
      strobe_r    <= 1'b0;
      sample_r    <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk;
      clk_sync_r  <= clk_meta_r;
      data_meta_r <= ps2_data;
      data_sync_r <= data_meta_r;
      if (clk_sync_r != filt_clk_r) begin
        if (filt_cnt_r == FILT_LAST) begin
          filt_clk_r <= clk_sync_r;
          filt_cnt_r <= FW'(0);
        end else begin
          filt_cnt_r <= filt_cnt_r + FW'(1);
        end
      end else begin
        filt_cnt_r <= FW'(0);
      end
      strobe_r <= fall_s;
      if (fall_s) begin
        sample_r <= data_sync_r;
      end
    end
  end

  // Frame FSM next-state, bit assembly and inter-strobe timeout.
  always_comb begin
    state_n   = state_r;
    bit_idx_n = bit_idx_r;
    shift_n   = shift_r;
    par_n     = par_r;
    timer_n   = timer_r;
    accept_s  = 1'b0;
    perr_s    = 1'b0;
    ferr_s    = 1'b0;

    case (state_r)
      IDLE: begin
        if (strobe_r) begin
          if (sample_r == 1'b0) begin
            state_n   = DATA;
            bit_idx_n = 3'd0;
          end else begin
            ferr_s = 1'b1;
          end
        end else begin
          state_n = IDLE;
        end
      end
      DATA: begin
        if (strobe_r) begin
          shift_n = {sample_r, shift_r[7:1]};
          if (bit_idx_r == 3'd7) begin
            state_n = PARITY;
          end else begin
            bit_idx_n = bit_idx_r + 3'd1;
          end
        end else begin
          state_n = DATA;
        end
      end
      PARITY: begin
        if (strobe_r) begin
          par_n   = sample_r;
          state_n = STOP;
        end else begin
          state_n = PARITY;
        end
      end
      STOP: begin
        if (strobe_r) begin
          state_n = IDLE;
          if (sample_r == 1'b0) begin
            ferr_s = 1'b1;
          end else if (odd_parity_ok(shift_r, par_r)) begin
            accept_s = 1'b1;
          end else begin
            perr_s = 1'b1;
          end
        end else begin
          state_n = STOP;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Timeout watchdog only runs while a frame is in progress.
    if (state_r != IDLE) begin
      if (strobe_r) begin
        timer_n = TW'(0);
      end else if (timer_r == TMO_LAST) begin
        timer_n = TW'(0);
        state_n = IDLE;
        ferr_s  = 1'b1;
      end else begin
        timer_n = timer_r + TW'(1);
      end
    end else begin
      timer_n = TW'(0);
    end
  end

  // Frame FSM state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'd0;
      par_r     <= 1'b0;
      timer_r   <= TW'(0);
    end else begin
      state_r   <= state_n;
      bit_idx_r <= bit_idx_n;
      shift_r   <= shift_n;
      par_r     <= par_n;
      timer_r   <= timer_n;
    end
  end

  // Error pulses, prefix tracking and event push towards the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      ext_pend_r <= 1'b0;
      brk_pend_r <= 1'b0;
      push_r     <= 1'b0;
      push_evt_r <= '{ext: 1'b0, brk: 1'b0, code: 8'd0};
    end else begin
      parity_err <= perr_s;
      frame_err  <= ferr_s;
      push_r     <= 1'b0;
      if (accept_s) begin
        if (shift_r == PS2_EXT) begin
          ext_pend_r <= 1'b1;
        end else if (shift_r == PS2_BRK) begin
          brk_pend_r <= 1'b1;
        end else begin
          push_r     <= 1'b1;
          push_evt_r <= '{ext: ext_pend_r, brk: brk_pend_r, code: shift_r};
          ext_pend_r <= 1'b0;
          brk_pend_r <= 1'b0;
        end
      end else if (perr_s || ferr_s) begin
        // A damaged frame may have been the key the prefixes belonged to.
        ext_pend_r <= 1'b0;
        brk_pend_r <= 1'b0;
      end
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PS2_EVT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_r),
    .push_data (push_evt_r),
    .pop       (rd_en),
    .clr_ovf   (clr_ovf),
    .head      (head_s),
    .valid     (valid),
    .level     (level),
    .overflow  (overflow)
  );

  assign head_evt_s = head_s;
  assign code       = head_evt_s.code;
  assign ext        = head_evt_s.ext;
  assign brk        = head_evt_s.brk;

endmodule

// File: tb/tb_ps2_key_rx.sv
// tb_ps2_key_rx -- scoreboard bench for ps2_key_rx (FIFO_DEPTH=4, FILTER_LEN=4,
// shortened PS/2 bit period and timeout). Stimulus pushes expected events into
// a queue; a monitor pops the DUT FIFO and compares against the queue head.
module tb_ps2_key_rx;

  localparam int DEPTH = 4;
  localparam int FLEN  = 4;
  localparam int TMO   = 200;
  localparam int H     = 10;          // clk cycles per PS/2 clock half period
  localparam int LAT   = 2 + FLEN;    // ps2_clk fall -> strobe register

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [7:0] code;
  logic       ext;
  logic       brk;
  logic       valid;
  logic [2:0] level;
  logic       overflow;
  logic       parity_err;
  logic       frame_err;

  int total = 0;
  int bad = 0;
  int perr_cnt = 0;
  int ferr_cnt = 0;
  int valid_at = -1;
  int fe_at = -1;
  bit auto_rd = 1'b0;
  logic [9:0] sb_q[$];

  ps2_key_rx #(
    .FIFO_DEPTH     (DEPTH),
    .FILTER_LEN     (FLEN),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rd_en      (rd_en),
    .clr_ovf    (clr_ovf),
    .code       (code),
    .ext        (ext),
    .brk        (brk),
    .valid      (valid),
    .level      (level),
    .overflow   (overflow),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: pops whenever reading is enabled and the DUT shows an event.
  initial begin
    logic [9:0] exp_evt;
    forever begin
      @(negedge clk);
      rd_en = 1'b0;
      if (!rst && auto_rd && valid) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: got 0x%0h expected none", {ext, brk, code});
        end else begin
          exp_evt = sb_q.pop_front();
          check("event", int'({ext, brk, code}), int'(exp_evt));
        end
        rd_en = 1'b1;
      end
    end
  end

  // Error pulse counters.
  initial begin
    forever begin
      @(negedge clk);
      if (parity_err) perr_cnt++;
      if (frame_err) ferr_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // One PS/2 bit: data set while clock high, then a low phase.
  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      repeat (H / 2) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (2) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (H - H / 2 - 2) @(negedge clk);
    end else begin
      repeat (H) @(negedge clk);
    end
    ps2_clk = 1'b0;
    valid_at = -1;
    for (int k = 1; k <= H; k++) begin
      @(posedge clk);
      #1;
      if (valid && valid_at < 0) valid_at = k;
    end
    @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par,
                            input logic stop, input bit glitch);
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
    send_bit((~^b) ^ flip_par, glitch);
    send_bit(stop, glitch);
    ps2_data = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    @(posedge clk);
    #2;
    auto_rd = 1'b1;
    while ((sb_q.size() != 0 || valid) && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    auto_rd = 1'b0;
    check({name, "_left"}, sb_q.size(), 0);
    check({name, "_level0"}, int'(level), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", int'(valid), 0);
    check("rst_level", int'(level), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_code", int'(code), 0);
    check("rst_ext", int'(ext), 0);
    check("rst_brk", int'(brk), 0);
    check("rst_perr", int'(parity_err), 0);
    check("rst_ferr", int'(frame_err), 0);

    // Single frame 1C, with latency of valid from the stop-bit clock fall.
    sb_q.push_back(10'h01C);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("t1_valid_lat", valid_at, LAT + 2);
    check("t1_level", int'(level), 1);
    drain("t1");

    // Prefixed release of an extended key.
    sb_q.push_back(10'h375);
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h75, 1'b0, 1'b1, 1'b0);
    check("t2_level", int'(level), 1);
    drain("t2");

    // Overflow: fifth event dropped.
    sb_q.push_back(10'h015);
    sb_q.push_back(10'h016);
    sb_q.push_back(10'h017);
    sb_q.push_back(10'h018);
    send_frame(8'h15, 1'b0, 1'b1, 1'b0);
    send_frame(8'h16, 1'b0, 1'b1, 1'b0);
    send_frame(8'h17, 1'b0, 1'b1, 1'b0);
    check("t3_ovf_before", int'(overflow), 0);
    send_frame(8'h18, 1'b0, 1'b1, 1'b0);
    send_frame(8'h19, 1'b0, 1'b1, 1'b0);
    check("t3_level_full", int'(level), 4);
    check("t3_ovf_set", int'(overflow), 1);
    drain("t3");
    check("t3_ovf_sticky", int'(overflow), 1);
    @(negedge clk);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("t3_ovf_clr", int'(overflow), 0);

    // Parity error, then a prefix with a bad stop bit, then a plain key.
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    check("t4_perr_cnt", perr_cnt, 1);
    check("t4_level_perr", int'(level), 0);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    check("t4_ferr_cnt", ferr_cnt, 1);
    check("t4_level_ferr", int'(level), 0);
    sb_q.push_back(10'h01C);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    drain("t4");

    // Timeout after start + 4 data bits.
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    fe_at = -1;
    for (int k = 1; k <= TMO + 50; k++) begin
      @(posedge clk);
      #1;
      if (k == H) ps2_clk = 1'b1;
      if (frame_err && fe_at < 0) fe_at = k;
    end
    check("t5_timeout_lat", fe_at, LAT + TMO);
    check("t5_ferr_cnt", ferr_cnt, 2);
    sb_q.push_back(10'h02A);
    send_frame(8'h2A, 1'b0, 1'b1, 1'b0);
    drain("t5");

    // Glitchy clock, reset mid-frame, then a glitchy full frame.
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_level", int'(level), 0);
    check("t6_rst_valid", int'(valid), 0);
    sb_q.push_back(10'h029);
    send_frame(8'h29, 1'b0, 1'b1, 1'b1);
    drain("t6");

    check("end_perr_cnt", perr_cnt, 1);
    check("end_ferr_cnt", ferr_cnt, 2);
    check("end_ovf", int'(overflow), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
